// File: rtl/des_req_arbiter_if.sv
// des_req_arbiter_if: requester, core and result signals of the shared DES arbiter
interface des_req_arbiter_if #(
    parameter int RES_DEPTH = 4
);
    logic                       req0_valid, req0_ready, req0_decrypt;
    logic [64:1]                req0_data, req0_key;
    logic                       req1_valid, req1_ready, req1_decrypt;
    logic [64:1]                req1_data, req1_key;
    logic                       core_issue, core_decrypt;
    logic [64:1]                core_din, core_key, core_dout;
    logic                       res_valid, res_ready, res_id, res_decrypt;
    logic [64:1]                res_data;
    logic [$clog2(RES_DEPTH):0] outstanding;

    modport slave (
        input  req0_valid, req0_data, req0_key, req0_decrypt,
        input  req1_valid, req1_data, req1_key, req1_decrypt,
        input  core_dout, res_ready,
        output req0_ready, req1_ready,
        output core_issue, core_din, core_key, core_decrypt,
        output res_valid, res_data, res_id, res_decrypt, outstanding
    );

    modport master (
        output req0_valid, req0_data, req0_key, req0_decrypt,
        output req1_valid, req1_data, req1_key, req1_decrypt,
        output core_dout, res_ready,
        input  req0_ready, req1_ready,
        input  core_issue, core_din, core_key, core_decrypt,
        input  res_valid, res_data, res_id, res_decrypt, outstanding
    );
endinterface

// File: rtl/des_req_arbiter.sv
// des_req_arbiter: round-robin sharing of one pipelined DES core between two requesters
module des_req_arbiter #(
    parameter int CORE_LAT  = 16,
    parameter int RES_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    des_req_arbiter_if.slave bus
);
    localparam int CW = $clog2(RES_DEPTH);
    localparam int PW = CW > 0 ? CW : 1;

    logic              prio_q, prio_d;
    logic [CW:0]       out_q, out_d, cnt_q, cnt_d;
    logic              credit_ok, g0, g1, acc, pop, wr;
    logic              issue_q, dec_q, id_q;
    logic [64:1]       din_q, key_q;
    logic [CORE_LAT-1:0] tv_q, tid_q, tdec_q;
    logic [65:0]       mem_q [RES_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;

    always_comb begin
        credit_ok = out_q < (CW+1)'(RES_DEPTH);
        g0 = credit_ok & bus.req0_valid & (~prio_q | ~bus.req1_valid);
        g1 = credit_ok & bus.req1_valid & (prio_q | ~bus.req0_valid);
        acc = g0 | g1;
        pop = (cnt_q != '0) & bus.res_ready;
        wr = tv_q[CORE_LAT-1];
        prio_d = acc ? g0 : prio_q;
        out_d = out_q + (CW+1)'(acc) - (CW+1)'(pop);
        cnt_d = cnt_q + (CW+1)'(wr) - (CW+1)'(pop);
    end

    // issue register doubles as tag stage 0; tv_q follows it for CORE_LAT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q  <= 1'b0;
            out_q   <= '0;
            cnt_q   <= '0;
            issue_q <= 1'b0;
            id_q    <= 1'b0;
            dec_q   <= 1'b0;
            din_q   <= '0;
            key_q   <= '0;
            tv_q    <= '0;
            tid_q   <= '0;
            tdec_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
        end else begin
            prio_q  <= prio_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            issue_q <= acc;
            if (acc) begin
                id_q  <= g1;
                dec_q <= g1 ? bus.req1_decrypt : bus.req0_decrypt;
                din_q <= g1 ? bus.req1_data : bus.req0_data;
                key_q <= g1 ? bus.req1_key : bus.req0_key;
            end
            tv_q   <= CORE_LAT'({tv_q, issue_q});
            tid_q  <= CORE_LAT'({tid_q, id_q});
            tdec_q <= CORE_LAT'({tdec_q, dec_q});
            if (wr)
                wp_q <= wp_q == PW'(RES_DEPTH-1) ? '0 : wp_q + 1'b1;
            if (pop)
                rp_q <= rp_q == PW'(RES_DEPTH-1) ? '0 : rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wp_q] <= {tid_q[CORE_LAT-1], tdec_q[CORE_LAT-1], bus.core_dout};
    end

    assign bus.req0_ready   = g0;
    assign bus.req1_ready   = g1;
    assign bus.core_issue   = issue_q;
    assign bus.core_din     = din_q;
    assign bus.core_key     = key_q;
    assign bus.core_decrypt = dec_q;
    assign bus.res_valid    = cnt_q != '0;
    assign {bus.res_id, bus.res_decrypt, bus.res_data} = mem_q[rp_q];
    assign bus.outstanding  = out_q;
endmodule

// File: tb/tb_des_req_arbiter.sv
// tb_des_req_arbiter: directed bench with a behavioural core model and an in-order result scoreboard
module tb_des_req_arbiter;
    localparam int CORE_LAT  = 16;
    localparam int RES_DEPTH = 4;
    localparam logic [64:1] P = 64'h0123456789ABCDEF;
    localparam logic [64:1] K = 64'h133457799BBCDFF1;
    localparam logic [64:1] C = 64'h85E813540F0AB405;

    typedef struct packed {
        logic        id;
        logic        dec;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_req_arbiter_if #(.RES_DEPTH(RES_DEPTH)) bus ();
    des_req_arbiter #(.CORE_LAT(CORE_LAT), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    exp_t sb[$];
    exp_t e_m;
    bit   gq[$];
    int   errs = 0, checks = 0, acc_cnt = 0, pops = 0;
    logic [64:1] cp [CORE_LAT];

    // known DES vector pair is reproduced exactly; other traffic uses a simple reversible stand-in
    function automatic logic [64:1] des_model(logic [64:1] d, logic [64:1] k, logic dec);
        if (k == K && !dec && d == P) return C;
        if (k == K && dec && d == C) return P;
        return {d[32:1], d[64:33]} ^ k ^ {64{dec}};
    endfunction

    always @(posedge clk) begin
        cp[0] <= des_model(bus.core_din, bus.core_key, bus.core_decrypt);
        for (int i = 1; i < CORE_LAT; i++) cp[i] <= cp[i-1];
    end
    assign bus.core_dout = cp[CORE_LAT-1];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("one_ready", 64'(bus.req0_ready & bus.req1_ready), 0);
            chk("ready_wo_valid", 64'((bus.req0_ready & ~bus.req0_valid) | (bus.req1_ready & ~bus.req1_valid)), 0);
            chk("out_max", 64'(bus.outstanding <= RES_DEPTH), 1);
            if (bus.req0_ready) sb.push_back({1'b0, bus.req0_decrypt, 64'(des_model(bus.req0_data, bus.req0_key, bus.req0_decrypt))});
            if (bus.req1_ready) sb.push_back({1'b1, bus.req1_decrypt, 64'(des_model(bus.req1_data, bus.req1_key, bus.req1_decrypt))});
            if (bus.res_valid && bus.res_ready) begin
                pops++;
                if (sb.size() == 0) chk("stale_result", 1, 0);
                else begin
                    e_m = sb.pop_front();
                    chk("res_data", bus.res_data, e_m.data);
                    chk("res_id", 64'(bus.res_id), 64'(e_m.id));
                    chk("res_decrypt", 64'(bus.res_decrypt), 64'(e_m.dec));
                end
            end
        end
    end

    task automatic step();
        logic a0, a1;
        a0 = bus.req0_ready;
        a1 = bus.req1_ready;
        @(posedge clk); #1;
        if (a0) begin
            bus.req0_data = {$urandom, $urandom};
            bus.req0_key = {$urandom, $urandom};
            bus.req0_decrypt = 1'($urandom);
            acc_cnt++;
            gq.push_back(1'b0);
        end
        if (a1) begin
            bus.req1_data = {$urandom, $urandom};
            bus.req1_key = {$urandom, $urandom};
            bus.req1_decrypt = 1'($urandom);
            acc_cnt++;
            gq.push_back(1'b1);
        end
    endtask

    task automatic send(bit id, logic [64:1] d, logic [64:1] k, bit dec);
        int n = 0;
        if (id) begin bus.req1_valid = 1; bus.req1_data = d; bus.req1_key = k; bus.req1_decrypt = dec; end
        else begin bus.req0_valid = 1; bus.req0_data = d; bus.req0_key = k; bus.req0_decrypt = dec; end
        #1;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 100) begin @(posedge clk); #1; n++; end
        chk("send_timeout", 64'(n < 100), 1);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
    endtask

    task automatic wait_res(output int n);
        n = 1;
        while (!bus.res_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("res_timeout", 64'(n < 100), 1);
    endtask

    task automatic drain();
        int n = 0;
        bus.res_ready = 1;
        while (bus.outstanding != 0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("drain", 64'(bus.outstanding), 0);
    endtask

    initial begin
        int n, p0;
        bus.req0_valid = 0; bus.req0_data = '0; bus.req0_key = '0; bus.req0_decrypt = 0;
        bus.req1_valid = 0; bus.req1_data = '0; bus.req1_key = '0; bus.req1_decrypt = 0;
        bus.res_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue", 64'(bus.core_issue), 0);
        chk("rst_res_valid", 64'(bus.res_valid), 0);
        chk("rst_outstanding", 64'(bus.outstanding), 0);
        chk("rst_din", bus.core_din, 0);
        rst = 0;
        @(posedge clk); #1;

        send(0, P, K, 0);
        chk("enc_issue", 64'(bus.core_issue), 1);
        chk("enc_din", bus.core_din, P);
        chk("enc_key", bus.core_key, K);
        chk("enc_mode", 64'(bus.core_decrypt), 0);
        @(posedge clk); #1;
        chk("issue_drop", 64'(bus.core_issue), 0);
        chk("din_hold", bus.core_din, P);
        wait_res(n);
        chk("enc_latency", 64'(n + 1), 64'(CORE_LAT + 2));
        chk("enc_data", bus.res_data, C);
        chk("enc_id", 64'(bus.res_id), 0);
        chk("enc_mode_out", 64'(bus.res_decrypt), 0);
        drain();

        send(1, C, K, 1);
        wait_res(n);
        chk("dec_data", bus.res_data, P);
        chk("dec_id", 64'(bus.res_id), 1);
        chk("dec_mode_out", 64'(bus.res_decrypt), 1);
        drain();

        gq.delete();
        acc_cnt = 0;
        n = 0;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        while (acc_cnt < 8 && n < 400) begin step(); n++; end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        chk("rr_count", 64'(acc_cnt), 8);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk($sformatf("rr_order%0d", i), 64'(gq[i]), 64'(i % 2));
        drain();

        bus.res_ready = 0;
        acc_cnt = 0;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        repeat (40) step();
        chk("credit_accepts", 64'(acc_cnt), RES_DEPTH);
        chk("credit_ready", 64'(bus.req0_ready | bus.req1_ready), 0);
        chk("credit_out", 64'(bus.outstanding), RES_DEPTH);
        chk("credit_res_valid", 64'(bus.res_valid), 1);

        bus.res_ready = 1;
        step();
        bus.res_ready = 0;
        chk("pop_out", 64'(bus.outstanding), RES_DEPTH - 1);
        chk("pop_ready", 64'(bus.req0_ready | bus.req1_ready), 1);
        bus.res_ready = 1;
        acc_cnt = 0;
        step();
        bus.res_ready = 0;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        chk("simul_accept", 64'(acc_cnt), 1);
        chk("simul_out", 64'(bus.outstanding), RES_DEPTH - 1);
        repeat (CORE_LAT + 4) begin @(posedge clk); #1; end
        chk("simul_hold", 64'(bus.outstanding), RES_DEPTH - 1);
        p0 = pops;
        drain();
        chk("fifo_count", 64'(pops - p0), RES_DEPTH - 1);

        acc_cnt = 0;
        n = 0;
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        while (acc_cnt < 3 && n < 50) begin step(); n++; end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_valid", 64'(bus.res_valid), 0);
        chk("mid_rst_out", 64'(bus.outstanding), 0);
        chk("mid_rst_issue", 64'(bus.core_issue), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        n = 0;
        repeat (CORE_LAT + 4) begin
            @(posedge clk); #1;
            n += int'(bus.res_valid);
        end
        chk("no_stale", 64'(n), 0);
        bus.req0_valid = 1; bus.req0_data = P; bus.req0_key = K; bus.req0_decrypt = 0;
        bus.req1_valid = 1; bus.req1_data = C; bus.req1_key = K; bus.req1_decrypt = 1;
        #1;
        chk("post_rst_prio0", 64'(bus.req0_ready), 1);
        chk("post_rst_prio1", 64'(bus.req1_ready), 0);
        @(posedge clk); #1;
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        wait_res(n);
        chk("post_rst_data", bus.res_data, C);
        chk("post_rst_id", 64'(bus.res_id), 0);
        drain();
        chk("sb_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
